// File: rtl/irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : irq_pending_ctrl
// Purpose  : 8-channel interrupt front end. It edge-detects the raw request
//            lines into a pending register and applies an enable mask. It
//            grants the highest enabled pending channel and completes an
//            irq/ack handshake with the consumer.
// Revision : 1.0 - initial release
// ============================================================================
module irq_pending_ctrl #(
  parameter int N   = 8,
  parameter int IDW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           mask_we,
  input  logic [N-1:0]   mask_wdata,
  input  logic           ack,
  output logic [N-1:0]   mask,
  output logic [N-1:0]   pending,
  output logic           irq,
  output logic [IDW-1:0] irq_id,
  output logic           in_service
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    ACKED  = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   req_d;
  logic [N-1:0]   rise;
  logic [N-1:0]   clr;
  logic [N-1:0]   eligible;
  logic [IDW-1:0] hi_idx;
  logic           hi_valid;

  assign rise     = req & ~req_d;
  assign eligible = pending & mask;
  assign hi_valid = |eligible;

  // Highest set index of the eligible vector; later (higher) bits overwrite lower ones
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i]) begin
        hi_idx = i[IDW-1:0];
      end
    end
  end

  // One-hot clear of the granted channel, only on the acknowledge that ends ASSERT
  always_comb begin
    clr = '0;
    if (state == ASSERT && ack) begin
      clr[irq_id] = 1'b1;
    end
  end

  // Previous request sample for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d <= '0;
    end else begin
      req_d <= req;
    end
  end

  // Pending register: a new rise takes precedence over a same-cycle clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | rise;
    end
  end

  // Enable mask register, written by the host strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask <= '0;
    end else if (mask_we) begin
      mask <= mask_wdata;
    end
  end

  // Grant handshake FSM; the grant is frozen from IDLE exit until ack is seen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      irq        <= 1'b0;
      irq_id     <= '0;
      in_service <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hi_valid) begin
            irq_id <= hi_idx;
            irq    <= 1'b1;
            state  <= ASSERT;
          end
        end
        ASSERT: begin
          if (ack) begin
            irq        <= 1'b0;
            in_service <= 1'b1;
            state      <= ACKED;
          end
        end
        ACKED: begin
          if (!ack) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          irq        <= 1'b0;
          in_service <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_pending_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_pending_ctrl
// Purpose  : Self-checking bench for irq_pending_ctrl. A cycle model pushes
//            expected outputs into a queue at every clock edge. They are
//            popped and compared shortly after the edge, and directed
//            checks follow the scenario sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_pending_ctrl;

  localparam int N   = 8;
  localparam int IDW = 3;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic           mask_we;
  logic [N-1:0]   mask_wdata;
  logic           ack;
  logic [N-1:0]   mask;
  logic [N-1:0]   pending;
  logic           irq;
  logic [IDW-1:0] irq_id;
  logic           in_service;

  irq_pending_ctrl #(.N(N), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ack        (ack),
    .mask       (mask),
    .pending    (pending),
    .irq        (irq),
    .irq_id     (irq_id),
    .in_service (in_service)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [N-1:0]   mask;
    logic [N-1:0]   pend;
    logic           irq;
    logic [IDW-1:0] id;
    logic           insvc;
  } exp_t;

  exp_t         sb_q[$];
  logic [N-1:0] m_mask, m_pend, m_reqd;
  logic         m_irq, m_insvc;
  logic [IDW-1:0] m_id;
  int           m_state; // 0 idle, 1 granted, 2 acknowledged

  function automatic logic [IDW-1:0] top_bit(input logic [N-1:0] v);
    logic [IDW-1:0] r;
    bit found;
    r = '0;
    found = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i] && !found) begin
        r = IDW'(i);
        found = 1;
      end
    end
    return r;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    logic [N-1:0] rs, cl;
    if (!rst_n) begin
      m_mask = '0; m_pend = '0; m_reqd = '0;
      m_irq = 0; m_insvc = 0; m_id = '0; m_state = 0;
    end else begin
      rs = req & ~m_reqd;
      cl = '0;
      if (m_state == 0) begin
        if ((m_pend & m_mask) != 0) begin
          m_id = top_bit(m_pend & m_mask);
          m_irq = 1;
          m_state = 1;
        end
      end else if (m_state == 1) begin
        if (ack) begin
          cl = N'(1) << m_id;
          m_irq = 0;
          m_insvc = 1;
          m_state = 2;
        end
      end else begin
        if (!ack) begin
          m_insvc = 0;
          m_state = 0;
        end
      end
      m_pend = (m_pend & ~cl) | rs;
      m_reqd = req;
      if (mask_we) m_mask = mask_wdata;
    end
    e.mask = m_mask; e.pend = m_pend; e.irq = m_irq; e.id = m_id; e.insvc = m_insvc;
    sb_q.push_back(e);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_mask",  32'(mask),       32'(e.mask));
      check("sb_pend",  32'(pending),    32'(e.pend));
      check("sb_irq",   32'(irq),        32'(e.irq));
      check("sb_insvc", 32'(in_service), 32'(e.insvc));
      if (e.irq) check("sb_id", 32'(irq_id), 32'(e.id));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic handshake();
    ack = 1'b1; tick(1);
    ack = 1'b0; tick(1);
    tick(1);
  endtask

  task automatic write_mask(input logic [N-1:0] m);
    mask_we = 1'b1; mask_wdata = m; tick(1);
    mask_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0;
    tick(2);
    check("rst_mask", 32'(mask), 32'h0);
    check("rst_pend", 32'(pending), 32'h0);
    check("rst_irq",  32'(irq), 32'h0);
    check("rst_id",   32'(irq_id), 32'h0);
    check("rst_insvc", 32'(in_service), 32'h0);
    rst_n = 1'b1;
    tick(1);

    // Single request with full handshake
    write_mask(8'hFF);
    req = 8'h20; tick(1);
    req = 8'h00;
    check("t1_pend", 32'(pending), 32'h20);
    check("t1_irq_lat", 32'(irq), 32'h0);
    tick(1);
    check("t1_irq", 32'(irq), 32'h1);
    check("t1_id",  32'(irq_id), 32'h5);
    ack = 1'b1; tick(1);
    check("t1_ack_pend", 32'(pending), 32'h0);
    check("t1_ack_irq",  32'(irq), 32'h0);
    check("t1_ack_insvc", 32'(in_service), 32'h1);
    ack = 1'b0; tick(1);
    check("t1_rel_insvc", 32'(in_service), 32'h0);
    tick(1);

    // Priority ordering of simultaneous rises
    req = 8'h25; tick(1);
    req = 8'h00; tick(1);
    check("t2_id5", 32'(irq_id), 32'h5);
    handshake();
    check("t2_id2", 32'(irq_id), 32'h2);
    check("t2_irq2", 32'(irq), 32'h1);
    handshake();
    check("t2_id0", 32'(irq_id), 32'h0);
    handshake();
    check("t2_pend", 32'(pending), 32'h0);
    check("t2_idle", 32'(irq), 32'h0);

    // Masked pending, unmask, grant freeze
    write_mask(8'h0F);
    req = 8'h40; tick(1);
    req = 8'h00; tick(2);
    check("t3_pend", 32'(pending), 32'h40);
    check("t3_masked", 32'(irq), 32'h0);
    write_mask(8'hFF);
    tick(1);
    check("t3_id6", 32'(irq_id), 32'h6);
    req = 8'h80; tick(1);
    req = 8'h00; tick(1);
    check("t3_frozen", 32'(irq_id), 32'h6);
    check("t3_pend2", 32'(pending), 32'hC0);
    handshake();
    check("t3_id7", 32'(irq_id), 32'h7);
    handshake();
    check("t3_pend0", 32'(pending), 32'h0);

    // Set wins over clear on the same edge
    req = 8'h08; tick(1);
    tick(1);
    check("t4_id3", 32'(irq_id), 32'h3);
    req = 8'h00; tick(1);
    req = 8'h08; ack = 1'b1; tick(1);
    check("t4_setwins", 32'(pending), 32'h08);
    check("t4_insvc", 32'(in_service), 32'h1);
    req = 8'h00; ack = 1'b0; tick(1);
    tick(1);
    check("t4_regrant", 32'(irq), 32'h1);
    check("t4_reid", 32'(irq_id), 32'h3);
    handshake();

    // Held level gives a single grant
    req = 8'h02; tick(2);
    check("t5_id1", 32'(irq_id), 32'h1);
    handshake();
    tick(4);
    check("t5_nogrant", 32'(irq), 32'h0);
    check("t5_nopend", 32'(pending), 32'h0);
    req = 8'h00; tick(1);
    req = 8'h02; tick(2);
    check("t5_regrant", 32'(irq), 32'h1);

    // Asynchronous reset while granted
    #2 rst_n = 1'b0;
    #1;
    check("t6_irq",  32'(irq), 32'h0);
    check("t6_pend", 32'(pending), 32'h0);
    check("t6_mask", 32'(mask), 32'h0);
    check("t6_insvc", 32'(in_service), 32'h0);
    tick(2);
    rst_n = 1'b1; tick(1);
    check("t6_heldrise", 32'(pending), 32'h02);
    check("t6_noirq", 32'(irq), 32'h0);
    req = 8'h00; tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
